ps2_kbd_rx: RTL
===============

# ps2_kbd_rx

Core-side PS/2 keyboard receiver: consumes the emulated `ps2_kbd_clk`/`ps2_kbd_data` pair driven by the IO controller block and deserialises 11-bit frames into bytes. It folds scan-code prefixes (E0, F0) into key events and queues them in a small FIFO for the Spectrum keyboard matrix logic. All logic runs in `clk_sys`.

## Interface
Parameters:
- `TIMEOUT`, 4096: `clk_sys` cycles without a PS/2 falling edge before a partial frame is aborted.
- `FIFO_BITS`, 2: log2 of the event FIFO depth (default 4 entries).

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock, idle high; treated as asynchronous.
- `ps2_data`  in  1  PS/2 data; treated as asynchronous.
- `rx_byte`  out  8  last good received byte; holds until next good byte.
- `rx_strobe`  out  1  one-cycle pulse, new `rx_byte`.
- `rx_err`  out  1  one-cycle pulse: bad parity, bad stop bit, or timeout.
- `evt_valid`  out  1  FIFO not empty.
- `evt_code`  out  8  head-of-FIFO scan code.
- `evt_ext`  out  1  head event was E0-prefixed.
- `evt_release`  out  1  head event was F0-prefixed (key up).
- `evt_rd`  in  1  pop head entry when `evt_valid`; ignored when empty.
- `overflow`  out  1  sticky: an event was dropped because FIFO was full; cleared only by `reset`.

## Operation
- Input sync: `ps2_clk` and `ps2_data` each through a 2-flop synchroniser; a falling edge is previous synced clk = 1, current = 0. Data is sampled from the synced data at the same cycle.
- Frame: start (0), 8 data bits LSB first, odd parity (data ones + parity bit odd), stop (1).
- FSM:
  - IDLE: on falling edge, sampled 0 → RECV with bit count 1; sampled 1 → ignored, stay IDLE, no error.
  - RECV: each falling edge shifts one bit, count increments. On the 11th bit (stop) → CHECK.
  - CHECK (single cycle): parity ok and stop = 1 → load `rx_byte`, pulse `rx_strobe`; else pulse `rx_err`. Always → IDLE.
  - Timeout: counter cleared on every falling edge and in IDLE; in RECV reaching `TIMEOUT` → IDLE, pulse `rx_err`.
- Prefix decoder, on each `rx_strobe`:
  - 0xE0 sets `ext_pend`.
  - 0xF0 sets `rel_pend`.
  - Any other byte (including E1, AA, FA, FE) pushes {`ext_pend`, `rel_pend`, byte} and clears both flags.
  - `rx_err` clears both flags.
- FIFO: 2^`FIFO_BITS` entries of 10 bits, wrap-around pointers plus count.
  - Push when full without a same-cycle pop: event dropped, `overflow` set.
  - Push and pop in the same cycle: both occur, including when full (no overflow) and when empty with a push (the new entry appears; the pop is ignored since `evt_valid` was 0).
- Reset values: `rx_byte` 0x00, `rx_strobe` 0, `rx_err` 0, `evt_valid` 0, `evt_code` 0x00, `evt_ext` 0, `evt_release` 0, `overflow` 0; FSM IDLE; prefixes, pointers and timeout counter 0.
- Reset mid-frame: remaining bits of that frame are either ignored (data 1) or mis-start a frame that ends in `rx_err` (parity/stop or timeout). No corrupted byte may be reported as good unless it is a legal frame.

## Timing
- Let N = first `clk_sys` edge where stage 1 samples `ps2_clk` low for the stop bit. The edge is detected at N+1, CHECK at N+2, `rx_strobe`/`rx_err` high during the cycle after edge N+2.
- Event push on the edge following `rx_strobe`; `evt_valid` and head outputs update one cycle later (`rx_strobe` → `evt_valid` = 2 cycles when empty).
- `evt_rd` sampled at a clock edge; the next entry or `evt_valid`=0 is visible the following cycle.
- Minimum supported PS/2 half-period: 4 `clk_sys` cycles. IO-controller default is about 101.
- Timeout counter width: ceil(log2(`TIMEOUT`+1)); `rx_err` fires exactly `TIMEOUT` cycles after the last detected falling edge.

## Test plan
- Frame 0x1C, parity 0, stop 1 at half-period 101 → one `rx_strobe`, `rx_byte`=0x1C; event {ext 0, rel 0, 0x1C}; `evt_valid` 2 cycles after strobe.
- Frames E0, F0, 74 → three `rx_strobe` pulses, exactly one event {ext 1, rel 1, 0x74}; `evt_rd` → `evt_valid`=0.
- F0, then 0x1C with parity 1, then 0x1C good → one `rx_err`, no strobe for the bad frame; single event {0, 0, 0x1C} (release flag cleared).
- Start plus 4 bits, then `ps2_clk` held high 5000 cycles → `rx_err` exactly 4096 cycles after the last edge; the following frame 0x29 is received correctly.
- Five events 0x15..0x19 with `evt_rd`=0 → `overflow`=1, four pops return 0x15..0x18 in order. Refill to full, then push and pop in the same cycle → count unchanged, no drop.
- `reset` asserted after bit 5 of frame 0x1C, sender finishes frame → no `rx_strobe` with corrupt data; the next frame 0x1C is received good; all outputs at reset values during reset.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 pair, deserialises 11-bit frames,
// folds E0/F0 prefixes into key events and queues them in a small FIFO.
module ps2_kbd_rx #(
    parameter int TIMEOUT   = 4096,
    parameter int FIFO_BITS = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_err,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    input  logic       evt_rd,
    output logic       overflow
);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_BITS;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic                 clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic                 fall;
    state_t               state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [8:0]           shift_q, shift_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]           byte_q, byte_d;
    logic                 strobe_q, strobe_d, err_q, err_d;
    logic                 ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
    logic                 push_q, push_d;
    logic [9:0]           push_data_q, push_data_d;
    logic [9:0]           mem_q [DEPTH], mem_d [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_BITS:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 do_push, do_pop, full;
    logic [9:0]           head;

    assign fall = clk_prev_q & ~clk_s2_q;

    // Frame FSM. The stop-bit edge both enters CHECK and registers the verdict,
    // so rx_strobe/rx_err are high exactly while the FSM sits in CHECK.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        byte_d    = byte_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (fall && !dat_s2_q) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = CHECK;
                        if (dat_s2_q && (^shift_q)) begin
                            byte_d   = shift_q[7:0];
                            strobe_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        shift_d = {dat_s2_q, shift_q[8:1]};
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    to_cnt_d = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prefix folding: E0/F0 only arm flags; any other byte becomes an event.
    always_comb begin
        ext_pend_d  = ext_pend_q;
        rel_pend_d  = rel_pend_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (err_q) begin
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else if (strobe_q) begin
            if (byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                rel_pend_d = 1'b1;
            end else begin
                push_d      = 1'b1;
                push_data_d = {ext_pend_q, rel_pend_q, byte_q};
                ext_pend_d  = 1'b0;
                rel_pend_d  = 1'b0;
            end
        end
    end

    assign full    = (count_q == (FIFO_BITS + 1)'(DEPTH));
    assign do_pop  = evt_rd && (count_q != '0);
    assign do_push = push_q && (!full || do_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_q & full & ~do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            byte_q      <= '0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            byte_q      <= byte_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
            ext_pend_q  <= ext_pend_d;
            rel_pend_q  <= rel_pend_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign rx_byte     = byte_q;
    assign rx_strobe   = strobe_q;
    assign rx_err      = err_q;
    assign evt_valid   = (count_q != '0);
    assign evt_code    = evt_valid ? head[7:0] : 8'h00;
    assign evt_ext     = evt_valid & head[9];
    assign evt_release = evt_valid & head[8];
    assign overflow    = overflow_q;
endmodule
